// File: rtl/pc_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage.
//   PC_W / INSTR_W / CNT_W : datapath widths
//   NOP                    : bubble encoding written into IF/ID on flush
//   fetch_state_e          : fetch FSM encodings
//   if_id_t                : IF/ID pipeline register payload
package pc_fetch_unit_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;

  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus4;
    logic               valid;
  } if_id_t;

  // Instructions are word aligned; the low two PC bits are never stored.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, async active-low reset
//   load       : capture d
//   flush      : replace instruction with NOP and drop valid (wins over all)
//   hold       : keep contents (wins over load)
//   d / q      : payload in / registered payload out
module if_id_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  logic   hold,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      // pc_plus4 is meaningless without valid, so it is left as is.
      q.instr <= NOP;
      q.valid <= 1'b0;
    end else if (!hold && load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT fetch FSM, saturating
// fetch counter, and the IF/ID register.
//   Clk, Reset_n          : clock, async active-low reset
//   Start                 : IDLE -> RUN
//   Stall                 : freeze PC, IF/ID, counter and state
//   Redirect, RedirectPc  : branch/jump target from decode (beats Stall)
//   InstrIn               : combinational memory data for ImAddress
//   ImAddress             : PC[7:0] to instruction memory
//   IfIdInstr/PcPlus4/Valid : IF/ID register contents
//   Halted                : fetch stopped on HALT_WORD
//   FetchCount            : instructions accepted into IF/ID, saturating
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectPc,
  input  logic [INSTR_W-1:0] InstrIn,
  output logic [7:0]         ImAddress,
  output logic [INSTR_W-1:0] IfIdInstr,
  output logic [PC_W-1:0]    IfIdPcPlus4,
  output logic               IfIdValid,
  output logic               Halted,
  output logic [CNT_W-1:0]   FetchCount
);

  fetch_state_e     state, state_n;
  logic [PC_W-1:0]  pc, pc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             halted, halted_n;
  logic             ld, fl, hd;
  if_id_t           ifid_d, ifid_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= ST_IDLE;
      pc     <= align_pc(RESET_PC);
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      cnt    <= cnt_n;
      halted <= halted_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    cnt_n    = cnt;
    halted_n = halted;
    ld       = 1'b0;
    fl       = 1'b0;
    hd       = 1'b0;
    if (Redirect) begin
      // In IDLE the flush is a no-op (IF/ID already holds NOP), so only the
      // PC effectively changes there.
      pc_n = align_pc(RedirectPc);
      fl   = 1'b1;
      if (state == ST_HALT) begin
        state_n  = ST_RUN;
        halted_n = 1'b0;
      end
    end else if (Stall) begin
      hd = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (Start) state_n = ST_RUN;
        ST_RUN: begin
          ld   = 1'b1;
          pc_n = pc + PC_W'(4);
          if (cnt != '1) cnt_n = cnt + CNT_W'(1);
          // The halt word itself is accepted; the bubble follows next cycle.
          if (InstrIn == HALT_WORD) state_n = ST_HALT;
        end
        ST_HALT: begin
          fl       = 1'b1;
          halted_n = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign ifid_d = '{instr: InstrIn, pc_plus4: pc + PC_W'(4), valid: 1'b1};

  if_id_reg u_if_id (
    .clk   (Clk),
    .rst_n (Reset_n),
    .load  (ld),
    .flush (fl),
    .hold  (hd),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ImAddress   = pc[7:0];
  assign IfIdInstr   = ifid_q.instr;
  assign IfIdPcPlus4 = ifid_q.pc_plus4;
  assign IfIdValid   = ifid_q.valid;
  assign Halted      = halted;
  assign FetchCount  = cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        Clk, Reset_n;
  logic        Start, Stall, Redirect;
  logic [31:0] RedirectPc, InstrIn;
  logic [7:0]  ImAddress;
  logic [31:0] IfIdInstr, IfIdPcPlus4;
  logic        IfIdValid, Halted;
  logic [15:0] FetchCount;

  logic        Start_w;
  logic [31:0] InstrIn_w;
  logic [7:0]  ImAddress_w;
  logic [31:0] IfIdInstr_w, IfIdPcPlus4_w;
  logic        IfIdValid_w, Halted_w;
  logic [15:0] FetchCount_w;

  logic [31:0] mem [0:63];

  typedef struct { logic [31:0] instr; logic [31:0] pc4; logic v; } exp_t;
  exp_t sb[$];
  exp_t e;

  int tests = 0;
  int fails = 0;

  assign InstrIn   = mem[ImAddress[7:2]];
  assign InstrIn_w = 32'h1000_0000 | {24'h0, ImAddress_w};

  pc_fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .Redirect(Redirect), .RedirectPc(RedirectPc), .InstrIn(InstrIn),
    .ImAddress(ImAddress), .IfIdInstr(IfIdInstr), .IfIdPcPlus4(IfIdPcPlus4),
    .IfIdValid(IfIdValid), .Halted(Halted), .FetchCount(FetchCount)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start_w), .Stall(1'b0),
    .Redirect(1'b0), .RedirectPc(32'h0), .InstrIn(InstrIn_w),
    .ImAddress(ImAddress_w), .IfIdInstr(IfIdInstr_w), .IfIdPcPlus4(IfIdPcPlus4_w),
    .IfIdValid(IfIdValid_w), .Halted(Halted_w), .FetchCount(FetchCount_w)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; Start = 0; Stall = 0; Redirect = 0; RedirectPc = 0; Start_w = 0;
    sb.delete();
    cyc();
    Reset_n = 1'b1;
    cyc();
  endtask

  task automatic do_start();
    Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 0; Stall = 0; Redirect = 0; RedirectPc = 0; Start_w = 0;
    #1;
    tests++;
    if (ImAddress !== 8'h0 || IfIdInstr !== 32'h0 || IfIdPcPlus4 !== 32'h0 ||
        IfIdValid !== 1'b0 || Halted !== 1'b0 || FetchCount !== 16'h0) begin
      fails++;
      $display("FAIL reset_values: addr=%h instr=%h pc4=%h v=%b h=%b cnt=%h, need all zero",
               ImAddress, IfIdInstr, IfIdPcPlus4, IfIdValid, Halted, FetchCount);
    end
    cyc();
    Reset_n = 1'b1;
    repeat (3) cyc();
    tests++;
    if (IfIdValid !== 1'b0 || ImAddress !== 8'h0 || FetchCount !== 16'h0) begin
      fails++;
      $display("FAIL idle_without_start: v=%b addr=%h cnt=%h, need 0/00/0",
               IfIdValid, ImAddress, FetchCount);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    do_start();
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{mem[k], 32'(4 * (k + 1)), 1'b1});
      cyc();
      e = sb.pop_front();
      tests++;
      if (IfIdInstr !== e.instr || IfIdPcPlus4 !== e.pc4 || IfIdValid !== e.v) begin
        fails++;
        $display("FAIL fetch_seq[%0d]: got %h/%h/%b, need %h/%h/%b", k,
                 IfIdInstr, IfIdPcPlus4, IfIdValid, e.instr, e.pc4, e.v);
      end
    end
    tests++;
    if (FetchCount !== 16'd4) begin
      fails++;
      $display("FAIL fetch_count: got %0d, need 4", FetchCount);
    end
  endtask

  task automatic test_stall();
    do_reset();
    do_start();
    repeat (2) cyc();
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests++;
      if (ImAddress !== 8'h08 || IfIdInstr !== mem[1] || IfIdPcPlus4 !== 32'd8 ||
          FetchCount !== 16'd2) begin
        fails++;
        $display("FAIL stall_hold[%0d]: addr=%h instr=%h pc4=%h cnt=%0d, need 08/%h/8/2",
                 k, ImAddress, IfIdInstr, IfIdPcPlus4, FetchCount, mem[1]);
      end
    end
    Stall = 1'b0;
    for (int k = 2; k < 4; k++) begin
      sb.push_back('{mem[k], 32'(4 * (k + 1)), 1'b1});
      cyc();
      e = sb.pop_front();
      tests++;
      if (IfIdInstr !== e.instr || IfIdPcPlus4 !== e.pc4 || IfIdValid !== e.v) begin
        fails++;
        $display("FAIL stall_resume[%0d]: got %h/%h/%b, need %h/%h/%b", k,
                 IfIdInstr, IfIdPcPlus4, IfIdValid, e.instr, e.pc4, e.v);
      end
    end
    tests++;
    if (FetchCount !== 16'd4) begin
      fails++;
      $display("FAIL stall_count: got %0d, need 4", FetchCount);
    end
  endtask

  // Runs straight after test_stall: PC=16, FetchCount=4.
  task automatic test_redirect();
    Redirect = 1'b1; RedirectPc = 32'h53; Stall = 1'b1;
    cyc();
    Redirect = 1'b0; Stall = 1'b0;
    tests++;
    if (ImAddress !== 8'h50 || IfIdValid !== 1'b0 || IfIdInstr !== 32'h0 ||
        FetchCount !== 16'd4) begin
      fails++;
      $display("FAIL redirect_flush: addr=%h v=%b instr=%h cnt=%0d, need 50/0/0/4",
               ImAddress, IfIdValid, IfIdInstr, FetchCount);
    end
    sb.push_back('{mem[20], 32'h54, 1'b1});
    cyc();
    e = sb.pop_front();
    tests++;
    if (IfIdInstr !== e.instr || IfIdPcPlus4 !== e.pc4 || IfIdValid !== e.v) begin
      fails++;
      $display("FAIL redirect_target: got %h/%h/%b, need %h/%h/%b",
               IfIdInstr, IfIdPcPlus4, IfIdValid, e.instr, e.pc4, e.v);
    end
    // Redirect while idle moves the PC but does not start fetching.
    do_reset();
    Redirect = 1'b1; RedirectPc = 32'h40;
    cyc();
    Redirect = 1'b0;
    repeat (2) cyc();
    tests++;
    if (ImAddress !== 8'h40 || IfIdValid !== 1'b0 || FetchCount !== 16'd0) begin
      fails++;
      $display("FAIL idle_redirect: addr=%h v=%b cnt=%0d, need 40/0/0",
               ImAddress, IfIdValid, FetchCount);
    end
    do_start();
    sb.push_back('{mem[16], 32'h44, 1'b1});
    cyc();
    e = sb.pop_front();
    tests++;
    if (IfIdInstr !== e.instr || IfIdPcPlus4 !== e.pc4 || IfIdValid !== e.v) begin
      fails++;
      $display("FAIL idle_redirect_fetch: got %h/%h/%b, need %h/%h/%b",
               IfIdInstr, IfIdPcPlus4, IfIdValid, e.instr, e.pc4, e.v);
    end
  endtask

  task automatic test_halt();
    logic [31:0] saved;
    saved  = mem[5];
    mem[5] = 32'hFFFF_FFFF;
    do_reset();
    do_start();
    for (int k = 0; k < 6; k++) begin
      sb.push_back('{mem[k], 32'(4 * (k + 1)), 1'b1});
      cyc();
      e = sb.pop_front();
      tests++;
      if (IfIdInstr !== e.instr || IfIdPcPlus4 !== e.pc4 || IfIdValid !== e.v) begin
        fails++;
        $display("FAIL halt_seq[%0d]: got %h/%h/%b, need %h/%h/%b", k,
                 IfIdInstr, IfIdPcPlus4, IfIdValid, e.instr, e.pc4, e.v);
      end
    end
    tests++;
    if (Halted !== 1'b0 || ImAddress !== 8'd24) begin
      fails++;
      $display("FAIL halt_accept: h=%b addr=%0d, need 0/24", Halted, ImAddress);
    end
    Start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests++;
      if (Halted !== 1'b1 || IfIdValid !== 1'b0 || IfIdInstr !== 32'h0 ||
          ImAddress !== 8'd24 || FetchCount !== 16'd6) begin
        fails++;
        $display("FAIL halt_state[%0d]: h=%b v=%b instr=%h addr=%0d cnt=%0d, need 1/0/0/24/6",
                 k, Halted, IfIdValid, IfIdInstr, ImAddress, FetchCount);
      end
    end
    Start = 1'b0;
    Redirect = 1'b1; RedirectPc = 32'h0;
    cyc();
    Redirect = 1'b0;
    tests++;
    if (Halted !== 1'b0 || ImAddress !== 8'h0 || IfIdValid !== 1'b0) begin
      fails++;
      $display("FAIL halt_redirect: h=%b addr=%h v=%b, need 0/00/0", Halted, ImAddress, IfIdValid);
    end
    sb.push_back('{mem[0], 32'h4, 1'b1});
    cyc();
    e = sb.pop_front();
    tests++;
    if (IfIdInstr !== e.instr || IfIdPcPlus4 !== e.pc4 || IfIdValid !== e.v) begin
      fails++;
      $display("FAIL halt_resume: got %h/%h/%b, need %h/%h/%b",
               IfIdInstr, IfIdPcPlus4, IfIdValid, e.instr, e.pc4, e.v);
    end
    mem[5] = saved;
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start();
    repeat (3) cyc();
    Stall = 1'b1; Redirect = 1'b1; RedirectPc = 32'h80;
    #3 Reset_n = 1'b0;
    #1;
    tests++;
    if (ImAddress !== 8'h0 || IfIdInstr !== 32'h0 || IfIdPcPlus4 !== 32'h0 ||
        IfIdValid !== 1'b0 || Halted !== 1'b0 || FetchCount !== 16'h0) begin
      fails++;
      $display("FAIL async_reset: addr=%h instr=%h pc4=%h v=%b h=%b cnt=%h, need all zero",
               ImAddress, IfIdInstr, IfIdPcPlus4, IfIdValid, Halted, FetchCount);
    end
    #2 Reset_n = 1'b1;
    Stall = 1'b0; Redirect = 1'b0;
    repeat (3) cyc();
    tests++;
    if (ImAddress !== 8'h0 || IfIdValid !== 1'b0 || FetchCount !== 16'h0) begin
      fails++;
      $display("FAIL post_reset_idle: addr=%h v=%b cnt=%0d, need 00/0/0",
               ImAddress, IfIdValid, FetchCount);
    end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    tests++;
    if (ImAddress_w !== 8'hFC) begin
      fails++;
      $display("FAIL wrap_reset_pc: addr=%h, need fc", ImAddress_w);
    end
    Start_w = 1'b1;
    cyc();
    Start_w = 1'b0;
    sb.push_back('{32'h1000_00FC, 32'h0, 1'b1});
    sb.push_back('{32'h1000_0000, 32'h4, 1'b1});
    for (int k = 0; k < 2; k++) begin
      cyc();
      e = sb.pop_front();
      tests++;
      if (IfIdInstr_w !== e.instr || IfIdPcPlus4_w !== e.pc4 || IfIdValid_w !== e.v) begin
        fails++;
        $display("FAIL wrap_seq[%0d]: got %h/%h/%b, need %h/%h/%b", k,
                 IfIdInstr_w, IfIdPcPlus4_w, IfIdValid_w, e.instr, e.pc4, e.v);
      end
    end
    repeat (65532) cyc();
    tests++;
    if (FetchCount_w !== 16'hFFFE) begin
      fails++;
      $display("FAIL count_fffe: got %h, need fffe", FetchCount_w);
    end
    repeat (2) cyc();
    tests++;
    if (FetchCount_w !== 16'hFFFF) begin
      fails++;
      $display("FAIL count_ffff: got %h, need ffff", FetchCount_w);
    end
    repeat (3) cyc();
    tests++;
    if (FetchCount_w !== 16'hFFFF || IfIdValid_w !== 1'b1) begin
      fails++;
      $display("FAIL count_saturate: cnt=%h v=%b, need ffff/1", FetchCount_w, IfIdValid_w);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_wrap_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
